lcd_hd44780_responder: RTL and testbench

//  Bus-side model of an HD44780 1602 controller: receives the RS/RW/EN/DB[7:0] parallel
//  bus driven by an LCD controller and decodes instructions and data writes.

---
 rtl/lcd_hd44780_responder.sv | 185 ++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: bus-side HD44780 1602 model with DDRAM mirror, mode state and read-back.
// Optional feature: define LCD_DISP_SHIFT_EN to add the ShiftQ display-offset output.
module lcd_hd44780_responder #(
    parameter int BUSY_CYC = 2000,
    parameter int CLR_CYC  = 76500
) (
    input  logic       C,
    input  logic       R,
    input  logic       RSA,
    input  logic       RWA,
    input  logic       ENA,
    input  logic [7:0] DataA,
    output logic [7:0] DataY,
    output logic       DataOEY,
    output logic       BusyY,
    output logic [6:0] ACQ,
    output logic [7:0] ModeQ,
    input  logic [4:0] RdAdrA,
    output logic [7:0] RdDataY,
`ifdef LCD_DISP_SHIFT_EN
    output logic [5:0] ShiftQ,
`endif
    output logic [7:0] DropCntQ
);
    localparam int CW = $clog2((CLR_CYC > BUSY_CYC ? CLR_CYC : BUSY_CYC) + 1);
    typedef enum logic [1:0] {S_FILL, S_IDLE, S_BUSY} state_t;
    state_t        state_q, state_d;
    logic [10:0]   sync1_q, sync2_q;
    logic          en_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    fill_q, fill_d;
    logic          clr_q, clr_d, oe_q, oe_d;
    logic [6:0]    ac_q, ac_d;
    logic [7:0]    mode_q, mode_d, drop_q, drop_d, dy_q, dy_d;
    logic [7:0]    mem_q [32];
    logic          mem_we, rs, rw, en, ev, vis;
    logic [4:0]    mem_wa, idx;
    logic [7:0]    mem_wd, db;
`ifdef LCD_DISP_SHIFT_EN
    logic [5:0]    shift_q, shift_d;
    function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
        return up ? (s == 6'd39 ? 6'd0 : s + 6'd1) : (s == 6'd0 ? 6'd39 : s - 6'd1);
    endfunction
    assign ShiftQ = shift_q;
`endif
    // Address counter stepping with the 1-line / 2-line wrap points
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic two, input logic inc);
        if (two)
            return inc ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
                       : (a == 7'h40 ? 7'h27 : a == 7'h00 ? 7'h67 : a - 7'd1);
        return inc ? (a == 7'h4F ? 7'h00 : a + 7'd1) : (a == 7'h00 ? 7'h4F : a - 7'd1);
    endfunction
    assign {rs, rw, en, db} = sync2_q;
    assign ev       = en_prev_q & ~en;
    assign vis      = (ac_q[6:4] == 3'b000) || (ac_q[6:4] == 3'b100);
    assign idx      = {ac_q[6], ac_q[3:0]};
    assign RdDataY  = mem_q[RdAdrA];
    assign ACQ      = ac_q;
    assign ModeQ    = mode_q;
    assign DropCntQ = drop_q;
    assign DataY    = dy_q;
    assign DataOEY  = oe_q;
    // State register, bus synchronizers and datapath registers
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            en_prev_q <= 1'b0;
            state_q   <= S_FILL;
            cnt_q     <= '0;
            fill_q    <= '0;
            clr_q     <= 1'b0;
            ac_q      <= '0;
            mode_q    <= 8'h82;
            drop_q    <= '0;
            dy_q      <= '0;
            oe_q      <= 1'b0;
`ifdef LCD_DISP_SHIFT_EN
            shift_q   <= '0;
`endif
        end else begin
            sync1_q   <= {RSA, RWA, ENA, DataA};
            sync2_q   <= sync1_q;
            en_prev_q <= en;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            clr_q     <= clr_d;
            ac_q      <= ac_d;
            mode_q    <= mode_d;
            drop_q    <= drop_d;
            dy_q      <= dy_d;
            oe_q      <= oe_d;
`ifdef LCD_DISP_SHIFT_EN
            shift_q   <= shift_d;
`endif
        end
    end
    // Mirror storage; FILL rewrites every byte after reset so it carries no reset
    always_ff @(posedge C) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end
    // Next state: FILL/BUSY sequencing and decode of bus events seen in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        clr_d   = clr_q;
        ac_d    = ac_q;
        mode_d  = mode_q;
        drop_d  = drop_q;
        mem_we  = 1'b0;
        mem_wa  = fill_q;
        mem_wd  = 8'h20;
`ifdef LCD_DISP_SHIFT_EN
        shift_d = shift_q;
`endif
        case (state_q)
            S_FILL: begin
                mem_we = 1'b1;
                fill_d = fill_q + 5'd1;
                if (fill_q == 5'd31) begin
                    state_d = clr_q ? S_BUSY : S_IDLE;
                    cnt_d   = CW'(CLR_CYC);
                    clr_d   = 1'b0;
                    if (clr_q) begin
                        ac_d      = '0;
                        mode_d[1] = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_IDLE;
            end
            default: ;
        endcase
        // Status reads (RS=0, RW=1) never change state and never count as drops
        if (ev && !(rw && !rs)) begin
            if (BusyY) drop_d = drop_q + {7'd0, drop_q != 8'hFF};
            else if (rs) begin
                ac_d = ac_step(ac_q, mode_q[6], mode_q[1]);
                if (!rw) begin
                    mem_we  = vis;
                    mem_wa  = idx;
                    mem_wd  = db;
                    state_d = S_BUSY;
                    cnt_d   = CW'(BUSY_CYC);
`ifdef LCD_DISP_SHIFT_EN
                    if (mode_q[0]) shift_d = shift_step(shift_q, mode_q[1]);
`endif
                end
            end else if (db == 8'h01) begin
                state_d = S_FILL;
                clr_d   = 1'b1;
            end else if (db[7:1] == 7'h01) begin
                ac_d    = '0;
                state_d = S_BUSY;
                cnt_d   = CW'(CLR_CYC);
`ifdef LCD_DISP_SHIFT_EN
                shift_d = '0;
`endif
            end else begin
                state_d = S_BUSY;
                cnt_d   = CW'(BUSY_CYC);
                if (db[7]) ac_d = db[6:0];
                else if (db[6]) ;
                else if (db[5]) mode_d[7:5] = db[4:2];
                else if (db[4]) begin
`ifdef LCD_DISP_SHIFT_EN
                    if (db[3]) shift_d = shift_step(shift_q, db[2]);
`endif
                end
                else if (db[3]) mode_d[4:2] = db[2:0];
                else if (db[2]) mode_d[1:0] = db[1:0];
            end
        end
    end
    // Outputs: busy flag and registered read data while the synchronized strobe is high
    always_comb begin
        BusyY = state_q != S_IDLE;
        oe_d  = en & rw;
        dy_d  = (en & rw) ? (rs ? (vis ? mem_q[idx] : 8'h20) : {BusyY, ac_q}) : dy_q;
    end
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: directed bus cycles checked against a behavioural HD44780 model.
module tb_lcd_hd44780_responder;
    localparam int BUSY = 50;
    localparam int CLR  = 3000;
    typedef struct {
        int         due;
        bit         rs;
        bit         rw;
        logic [7:0] db;
    } ev_t;
    logic       clk = 1'b0, rst = 1'b1, rsa = 1'b0, rwa = 1'b0, ena = 1'b0;
    logic [7:0] dataa = '0;
    logic [4:0] rdadr = '0;
    logic [7:0] data_y, mode_y, rd_y, drop_y;
    logic       oe_y, busy_y;
    logic [6:0] ac_y;
`ifdef LCD_DISP_SHIFT_EN
    logic [5:0] shift_y;
`endif
    int         n_chk = 0, n_fail = 0, cyc = 0, adr_sel = -1, len;
    bit         run = 1'b0, reading = 1'b0;
    logic [7:0] last_rd;
    int         m_busy, m_fill, m_drop;
    logic [6:0] m_ac;
    bit         m_dl, m_n, m_f, m_d, m_c, m_b, m_id, m_s;
    logic [7:0] m_mem [32];
    ev_t        evq[$];

    lcd_hd44780_responder #(.BUSY_CYC(BUSY), .CLR_CYC(CLR)) dut (
        .C(clk), .R(rst), .RSA(rsa), .RWA(rwa), .ENA(ena), .DataA(dataa),
        .DataY(data_y), .DataOEY(oe_y), .BusyY(busy_y), .ACQ(ac_y), .ModeQ(mode_y),
        .RdAdrA(rdadr), .RdDataY(rd_y),
`ifdef LCD_DISP_SHIFT_EN
        .ShiftQ(shift_y),
`endif
        .DropCntQ(drop_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int vis_idx(input logic [6:0] a);
        if (a < 7'h10) return int'(a);
        if (a >= 7'h40 && a < 7'h50) return int'(a) - 'h40 + 16;
        return -1;
    endfunction

    // Lines as rings of 80 positions: two lines of 40 when N=1, one line of 80 when N=0
    function automatic logic [6:0] next_ac(input logic [6:0] a);
        int p;
        int d = m_id ? 1 : 79;
        if (m_n) begin
            p = (a < 7'h40) ? int'(a) : int'(a) - 'h40 + 40;
            p = (p + d) % 80;
            return (p < 40) ? 7'(p) : 7'(p - 40 + 'h40);
        end
        return 7'((int'(a) + d) % 80);
    endfunction

    task automatic apply(input ev_t e, input bit was_busy);
        if (!e.rs && e.rw) return;
        if (was_busy) begin
            if (m_drop < 255) m_drop++;
            return;
        end
        if (e.rs) begin
            if (!e.rw) begin
                if (vis_idx(m_ac) >= 0) m_mem[vis_idx(m_ac)] = e.db;
                m_busy = BUSY;
            end
            m_ac = next_ac(m_ac);
            return;
        end
        m_busy = BUSY;
        if (e.db == 8'h01) begin
            m_busy = 32 + CLR;
            m_fill = 32;
        end
        else if (e.db == 8'h02 || e.db == 8'h03) begin
            m_ac   = '0;
            m_busy = CLR;
        end
        else if (e.db >= 8'h80) m_ac = e.db[6:0];
        else if (e.db >= 8'h40) ;
        else if (e.db >= 8'h20) {m_dl, m_n, m_f} = e.db[4:2];
        else if (e.db >= 8'h10) ;
        else if (e.db >= 8'h08) {m_d, m_c, m_b} = e.db[2:0];
        else if (e.db >= 8'h04) {m_id, m_s} = e.db[1:0];
    endtask

    initial forever begin
        bit wb;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 32;
            m_fill = 32;
            m_drop = 0;
            m_ac   = '0;
            {m_dl, m_n, m_f, m_d, m_c, m_b, m_id, m_s} = 8'h82;
            evq.delete();
        end else begin
            cyc++;
            wb = m_busy > 0;
            if (m_busy > 0) m_busy--;
            if (m_fill > 0) begin
                m_fill--;
                if (m_fill == 0) begin
                    foreach (m_mem[i]) m_mem[i] = 8'h20;
                    m_ac = '0;
                    m_id = 1'b1;
                end
            end
            if (evq.size() > 0 && evq[0].due == cyc) apply(evq.pop_front(), wb);
        end
    end

    initial begin
        int ri = 0;
        forever begin
            @(negedge clk);
            rdadr = adr_sel >= 0 ? 5'(adr_sel) : 5'(ri);
            #1;
            if (run) begin
                chk("busy", busy_y, m_busy > 0);
                chk("acq", ac_y, m_ac);
                chk("mode", mode_y, {m_dl, m_n, m_f, m_d, m_c, m_b, m_id, m_s});
                chk("drop", drop_y, m_drop);
                if (m_fill == 0) chk("mirror", rd_y, m_mem[rdadr]);
                if (!reading) chk("oe_idle", oe_y, 0);
            end
            ri = (ri + 1) % 32;
        end
    end

    task automatic bus(input bit rs, input bit rw, input logic [7:0] db);
        ev_t        e;
        logic [7:0] exp;
        @(posedge clk);
        #1;
        rsa = rs; rwa = rw; dataa = db; ena = 1'b1; reading = rw;
        repeat (4) @(posedge clk);
        if (rw) begin
            @(negedge clk);
            #2;
            exp = rs ? (vis_idx(m_ac) >= 0 ? m_mem[vis_idx(m_ac)] : 8'h20) : {m_busy > 0, m_ac};
            chk("rd_oe", oe_y, 1);
            chk("rd_data", data_y, exp);
            last_rd = data_y;
            @(posedge clk);
        end
        #1;
        ena = 1'b0;
        e.due = cyc + 3; e.rs = rs; e.rw = rw; e.db = db;
        evq.push_back(e);
        repeat (4) @(posedge clk);
        #1;
        reading = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_y && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (busy_y) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: BusyY still 1 after %0d cycles", t);
        end
    endtask

    task automatic wr(input logic [7:0] db);
        bus(1'b0, 1'b0, db);
        wait_idle();
    endtask

    task automatic measure(input bit wait_rise, output int n);
        int t = 0;
        n = 0;
        if (wait_rise) begin
            while (!busy_y && t < 40) begin
                @(negedge clk);
                t++;
            end
        end else @(negedge clk);
        while (busy_y && n < 2 * CLR) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pin_mirror(input string name, input int a, input logic [7:0] exp);
        adr_sel = a;
        @(negedge clk);
        #2;
        chk(name, rd_y, exp);
        adr_sel = -1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acq", ac_y, 7'h00);
        chk("rst_mode", mode_y, 8'h82);
        chk("rst_drop", drop_y, 8'h00);
        chk("rst_oe", oe_y, 0);
        chk("rst_datay", data_y, 8'h00);
        run = 1'b1;
        rst = 1'b0;
        measure(1'b0, len);
        chk("fill_len", len, 32);
        repeat (40) @(posedge clk);
        pin_mirror("fill_byte31", 31, 8'h20);
        wr(8'h38);
        wr(8'h0C);
        fork
            bus(1'b0, 1'b0, 8'h06);
            measure(1'b1, len);
        join
        chk("write_busy_len", len, BUSY);
        wait_idle();
        wr(8'h80);
        bus(1'b1, 1'b0, 8'h48);
        wait_idle();
        chk("init_mode", mode_y, 8'hD2);
        chk("init_acq", ac_y, 7'h01);
        pin_mirror("mirror0_H", 0, 8'h48);
        wr(8'hC0);
        bus(1'b1, 1'b0, 8'h41);
        wait_idle();
        pin_mirror("mirror16", 16, 8'h41);
        bus(1'b0, 1'b1, 8'h00);
        chk("status_read", last_rd, 8'h41);
        wr(8'h80);
        bus(1'b1, 1'b1, 8'h00);
        chk("data_read", last_rd, 8'h48);
        chk("data_read_acq", ac_y, 7'h01);
        wr(8'hA7);
        bus(1'b1, 1'b0, 8'h58);
        wait_idle();
        chk("wrap_27_40", ac_y, 7'h40);
        wr(8'h80);
        wr(8'h04);
        bus(1'b1, 1'b0, 8'h5A);
        wait_idle();
        chk("wrap_00_67", ac_y, 7'h67);
        pin_mirror("mirror0_dec", 0, 8'h5A);
        wr(8'h1C);
        wr(8'h07);
        chk("entry_s", mode_y, 8'hD3);
        wr(8'h06);
        wr(8'h30);
        wr(8'hCF);
        bus(1'b1, 1'b0, 8'h21);
        wait_idle();
        chk("wrap_1line", ac_y, 7'h00);
        pin_mirror("mirror31", 31, 8'h21);
        wr(8'h38);
        fork
            begin
                bus(1'b0, 1'b0, 8'h01);
                repeat (500) @(posedge clk);
                bus(1'b1, 1'b0, 8'h48);
            end
            measure(1'b1, len);
        join
        chk("clear_busy_len", len, 32 + CLR);
        chk("clear_drop", drop_y, 8'd1);
        chk("clear_acq", ac_y, 7'h00);
        repeat (40) @(posedge clk);
        bus(1'b1, 1'b0, 8'h41);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_acq", ac_y, 7'h00);
        chk("midrst_drop", drop_y, 8'd0);
        chk("midrst_busy", busy_y, 1);
        rst = 1'b0;
        measure(1'b0, len);
        chk("refill_len", len, 32);
        bus(1'b0, 1'b0, 8'h01);
        for (int i = 0; i < 300; i++) bus(1'b1, 1'b0, 8'h33);
        chk("drop_sat", drop_y, 8'd255);
        wait_idle();
        repeat (40) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
